// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
package div_pkg;

    // Controller states: waiting for a command, iterating, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 8;

endpackage

// File: rtl/restoring_divider_8bit_if.sv
// Board-side bundle of the divider: switch input, control strobes, and result/status.
interface restoring_divider_8bit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Switches;
    logic             ClearA_loadB_h;
    logic             Execute_h;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Busy;
    logic             Done;
    logic             DivZero;

    // Board/test side drives the controls and reads the results.
    modport master (
        output Switches, ClearA_loadB_h, Execute_h,
        input  Aval, Bval, Busy, Done, DivZero
    );

    // Divider side consumes the controls and presents the results.
    modport slave (
        input  Switches, ClearA_loadB_h, Execute_h,
        output Aval, Bval, Busy, Done, DivZero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,B} left, trial-subtract S, restore on borrow.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next
);

    logic [WIDTH-1:0] t;
    logic [WIDTH:0]   d;

    // Shift in the next dividend bit, subtract with one extra bit to expose the borrow.
    always_comb begin
        t      = {a[WIDTH-2:0], b[WIDTH-1]};
        d      = {1'b0, t} - {1'b0, s};
        a_next = d[WIDTH] ? t : d[WIDTH-1:0];
        b_next = {b[WIDTH-2:0], ~d[WIDTH]};
    end

endmodule

// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned restoring divider: A = remainder, B = quotient, one bit per clock.
module restoring_divider_8bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    restoring_divider_8bit_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic [CW-1:0]    count_reg;
    logic             div_zero_reg;

    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_reg),
        .b      (b_reg),
        .s      (s_reg),
        .a_next (a_next),
        .b_next (b_next)
    );

    // Controller and datapath registers; S is latched at start so the switches may move mid-run.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            s_reg        <= '0;
            count_reg    <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Load takes priority over execute when both are asserted.
                    if (bus.ClearA_loadB_h) begin
                        a_reg        <= '0;
                        b_reg        <= bus.Switches;
                        div_zero_reg <= 1'b0;
                    end else if (bus.Execute_h) begin
                        s_reg        <= bus.Switches;
                        a_reg        <= '0;
                        count_reg    <= '0;
                        div_zero_reg <= (bus.Switches == '0);
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_next;
                    b_reg     <= b_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_STEP) begin
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    // Wait for Execute_h to drop so a held level runs only once.
                    if (!bus.Execute_h) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.Aval    = a_reg;
    assign bus.Bval    = b_reg;
    assign bus.Busy    = (state_reg == RUN);
    assign bus.Done    = (state_reg == HOLD);
    assign bus.DivZero = div_zero_reg;

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Directed-vector bench for restoring_divider_8bit.
module tb_restoring_divider_8bit;
    import div_pkg::*;

    logic Clk;
    logic Reset_n;
    int   pass_cnt;
    int   check_cnt;

    restoring_divider_8bit_if #(.WIDTH(DIV_WIDTH)) dif ();

    restoring_divider_8bit #(.WIDTH(DIV_WIDTH)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (dif.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
            $display("ok   %s obs=%0h", tag, obs);
        end else begin
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] val);
        dif.Switches       = val;
        dif.ClearA_loadB_h = 1'b1;
        @(negedge Clk);
        dif.ClearA_loadB_h = 1'b0;
    endtask

    // Start a divide, count edges until Done, check the result, then release Execute_h.
    task automatic do_div(input string tag, input logic [7:0] divisor,
                          input logic [7:0] exp_q, input logic [7:0] exp_r,
                          input logic exp_dz);
        int edges;
        edges = 0;
        dif.Switches  = divisor;
        dif.Execute_h = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            edges++;
            #1;
            dif.Switches = ~divisor;   // must be ignored once running
            if (dif.Done) break;
        end
        check_eq({tag, "_latency"}, edges, 9);
        @(negedge Clk);
        check_eq({tag, "_q"}, dif.Bval, exp_q);
        check_eq({tag, "_r"}, dif.Aval, exp_r);
        check_eq({tag, "_dz"}, dif.DivZero, exp_dz);
        check_eq({tag, "_done"}, dif.Done, 1);
        dif.Execute_h = 1'b0;
        @(negedge Clk);
        check_eq({tag, "_idle"}, dif.Done, 0);
    endtask

    initial begin
        int busy_cycles;
        pass_cnt  = 0;
        check_cnt = 0;
        dif.Switches       = '0;
        dif.ClearA_loadB_h = 1'b0;
        dif.Execute_h      = 1'b0;
        Reset_n            = 1'b0;
        #3;
        check_eq("rst_a", dif.Aval, 0);
        check_eq("rst_b", dif.Bval, 0);
        check_eq("rst_busy", dif.Busy, 0);
        check_eq("rst_done", dif.Done, 0);
        check_eq("rst_dz", dif.DivZero, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // 197 / 7 = 28 r 1, then chained 28 / 4 = 7 r 0
        do_load(8'hC5);
        check_eq("load_b", dif.Bval, 8'hC5);
        do_div("c5_by_07", 8'h07, 8'h1C, 8'h01, 1'b0);
        do_div("chain_by_04", 8'h04, 8'h07, 8'h00, 1'b0);

        // divide by zero, then a load clears the flag
        do_load(8'h2A);
        do_div("2a_by_00", 8'h00, 8'hFF, 8'h2A, 1'b1);
        do_load(8'h10);
        check_eq("load_clears_dz", dif.DivZero, 0);

        do_load(8'h05);
        do_div("05_by_09", 8'h09, 8'h00, 8'h05, 1'b0);
        do_load(8'hFF);
        do_div("ff_by_01", 8'h01, 8'hFF, 8'h00, 1'b0);

        // Held Execute_h: exactly one run of 8 busy cycles
        do_load(8'h64);
        dif.Switches  = 8'h0A;
        dif.Execute_h = 1'b1;
        busy_cycles   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (dif.Busy) busy_cycles++;
        end
        check_eq("hold_busy_cycles", busy_cycles, 8);
        check_eq("hold_q", dif.Bval, 8'h0A);
        check_eq("hold_r", dif.Aval, 8'h00);
        check_eq("hold_done", dif.Done, 1);
        dif.Execute_h = 1'b0;
        @(negedge Clk);

        // Asynchronous reset in the 4th RUN cycle
        do_load(8'h2A);
        dif.Switches  = 8'h00;
        dif.Execute_h = 1'b1;
        @(posedge Clk);
        for (int i = 0; i < 3; i++) @(posedge Clk);
        #2;
        check_eq("pre_rst_busy", dif.Busy, 1);
        check_eq("pre_rst_dz", dif.DivZero, 1);
        Reset_n = 1'b0;
        #1;
        check_eq("mid_rst_a", dif.Aval, 0);
        check_eq("mid_rst_b", dif.Bval, 0);
        check_eq("mid_rst_busy", dif.Busy, 0);
        check_eq("mid_rst_done", dif.Done, 0);
        check_eq("mid_rst_dz", dif.DivZero, 0);
        dif.Execute_h = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_eq("post_rst_busy", dif.Busy, 0);

        // Load and execute together: load wins, no run
        dif.Switches       = 8'h33;
        dif.ClearA_loadB_h = 1'b1;
        dif.Execute_h      = 1'b1;
        @(negedge Clk);
        dif.ClearA_loadB_h = 1'b0;
        dif.Execute_h      = 1'b0;
        check_eq("both_b", dif.Bval, 8'h33);
        check_eq("both_busy", dif.Busy, 0);
        @(negedge Clk);
        check_eq("both_busy_later", dif.Busy, 0);
        check_eq("both_done", dif.Done, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
